melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//   Upstream stage of the tone divider. Steps through a fixed note pattern and drives
//   the divider's 7-bit `modulador` input plus a `gate` that enables the tone.
//   Each note is held for a programmed number of duration ticks, followed by a silent gap.
//   Supports one-shot and looped playback, an optional transpose offset, and stop/abort.
// PARAMETERS
//   FrecIn     25000  input clock frequency in Hz (same clock as the divider)
//   TICK_HZ    100    duration tick rate in Hz; TICK_CYC = FrecIn/TICK_HZ clocks per tick
//   NUM_STEPS  16     pattern ROM depth; power of 2, max 16
//   GAP_TICKS  2      silent ticks between notes; 0 = no gap
// PORTS
//   clockIn    in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   start      in   1  one-cycle pulse; begins playback at step 0 when idle
//   stop       in   1  one-cycle pulse; aborts playback
//   loop_en    in   1  1 = restart at step 0 after the end of the pattern
//   offset     in   7  transpose, added to the ROM modulation value
//   modulador  out  7  modulation value for the divider (registered)
//   gate       out  1  1 while a note sounds (registered)
//   step_idx   out  4  index of the current step
//   busy       out  1  1 in any state except IDLE
//   done       out  1  one-cycle pulse when one-shot playback ends
// BEHAVIOUR
//   Reset: state=IDLE; modulador=0, gate=0, step_idx=0, busy=0, done=0; prescaler=0.
//   ROM entry = {mod[6:0], dur[4:0]}. dur==0 is the end-of-pattern marker.
//     Step NUM_STEPS-1 is also treated as the end: it plays, then the end rule applies.
//   Prescaler: counts 0..TICK_CYC-1 and pulses `tick` on the wrap.
//     Cleared on every entry to PLAY and GAP.
//     So a note lasts exactly dur*TICK_CYC clocks and a gap exactly GAP_TICKS*TICK_CYC clocks.
//   FSM states: IDLE, LOAD, PLAY, GAP, DONE.
//     IDLE: start -> LOAD with step_idx=0. start while busy is ignored.
//     LOAD (2 cycles; ROM read is registered):
//       dur==0 -> END rule.
//       Otherwise: modulador <= sat127(mod+offset), dur_cnt <= dur, gate <= 1, go to PLAY.
//     PLAY: on tick, dur_cnt--. When tick arrives with dur_cnt==1: gate <= 0.
//       Then GAP if GAP_TICKS>0, else next-step rule.
//     GAP: counts GAP_TICKS ticks, then next-step rule.
//     Next-step rule: if step_idx==NUM_STEPS-1 -> END rule; else step_idx++ and go to LOAD.
//     END rule: if loop_en (sampled at this point) -> step_idx=0 and go to LOAD.
//       Otherwise go to DONE.
//     DONE: done=1 for exactly one cycle, then IDLE.
//   Arithmetic: 8-bit sum of mod and offset; a result >127 saturates to 127. Width never wraps.
//   modulador holds its last value in GAP, DONE and IDLE; only gate mutes the tone.
//   stop in any non-IDLE state: next cycle state=IDLE, gate=0, busy=0.
//     step_idx, done and modulador do not change on stop; no done pulse is issued.
//   Simultaneous start and stop: stop wins and the block stays or returns to IDLE.
//   reset mid-note: all outputs go to their reset values on the next edge.
// STRUCTURE
//   Shared header seq_defs.vh holds:
//     state encodings (IDLE=0, LOAD=1, PLAY=2, GAP=3, DONE=4);
//     ROM field widths (MOD_W=7, DUR_W=5);
//     ENTRY_W=12.
//   Sub-module seq_rom: synchronous-read pattern ROM, NUM_STEPS x ENTRY_W, 1-cycle latency.
//     Default contents: {0,3}, {20,1}, {127,2}, then dur=0 for all remaining entries.
//   melody_sequencer holds the FSM, prescaler, duration/gap counters and saturating adder.
// TESTING (FrecIn=100, TICK_HZ=10 -> TICK_CYC=10; GAP_TICKS=1; default ROM)
//   1. Reset, then start with offset=0, loop_en=0 -> sequence below, then done pulses once
//      and busy drops.
//      - gate high for 30 clocks with modulador=0;
//      - gap of 10 clocks;
//      - gate high for 10 clocks with modulador=20;
//      - gap of 10 clocks;
//      - gate high for 20 clocks with modulador=127.
//   2. offset=110 -> modulador values 110, 127 (saturated), 127. No wrap to small values.
//   3. loop_en=1 -> after step 2's gap, step_idx returns to 0 and modulador=0 again.
//      done stays 0.
//   4. stop pulse in the middle of note 1 -> gate=0 and busy=0 next cycle, no done pulse.
//      A later start replays from step 0.
//   5. start and stop in the same cycle while IDLE -> remains IDLE.
//      start while busy -> step timing unchanged.
//   6. reset asserted during PLAY -> next edge: modulador=0, gate=0, step_idx=0, busy=0.

Source files
------------

// File: rtl/melody_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : melody_sequencer_pkg                                             |
// | Purpose  : Shared state encoding, ROM field widths and saturating adder.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package melody_sequencer_pkg;

    localparam int c_MOD_W   = 7;
    localparam int c_DUR_W   = 5;
    localparam int c_ENTRY_W = c_MOD_W + c_DUR_W;
    localparam int c_IDX_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } seq_state_e;

    // One extra bit of headroom; any carry into it means the sum exceeded 127.
    function automatic logic [c_MOD_W-1:0] sat_add(input logic [c_MOD_W-1:0] a,
                                                   input logic [c_MOD_W-1:0] b);
        logic [c_MOD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[c_MOD_W] ? {c_MOD_W{1'b1}} : sum[c_MOD_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/melody_sequencer_seq_rom.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : seq_rom                                                          |
// | Purpose  : Pattern ROM {mod, dur}, synchronous read with 1-cycle latency.   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module seq_rom
    import melody_sequencer_pkg::*;
#(
    parameter int NUM_STEPS = 16
) (
    input  logic                 clockIn,
    input  logic [c_IDX_W-1:0]   i_addr,
    output logic [c_ENTRY_W-1:0] o_data
);

    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] r_data;

    always_comb begin
        w_entry = '0;
        case (i_addr)
            4'd0:    w_entry = {7'd0,   5'd3};
            4'd1:    w_entry = {7'd20,  5'd1};
            4'd2:    w_entry = {7'd127, 5'd2};
            default: w_entry = '0;
        endcase
    end

    // Addresses beyond the configured depth read as end-of-pattern markers.
    always_ff @(posedge clockIn) begin
        r_data <= (int'(i_addr) < NUM_STEPS) ? w_entry : '0;
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : melody_sequencer                                                 |
// | Purpose  : Steps a note pattern, driving modulador/gate for the tone divider.|
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int FREC_IN   = 25000,
    parameter int TICK_HZ   = 100,
    parameter int NUM_STEPS = 16,
    parameter int GAP_TICKS = 2
) (
    input  logic               clockIn,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [c_MOD_W-1:0] offset,
    output logic [c_MOD_W-1:0] modulador,
    output logic               gate,
    output logic [c_IDX_W-1:0] step_idx,
    output logic               busy,
    output logic               done
);

    localparam int c_TICK_CYC = FREC_IN / TICK_HZ;
    localparam int c_PRE_W    = (c_TICK_CYC > 1) ? $clog2(c_TICK_CYC) : 1;
    localparam int c_GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [c_PRE_W-1:0] c_TICK_LAST = c_PRE_W'(c_TICK_CYC - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD  = c_GAP_W'(GAP_TICKS);
    localparam logic [c_IDX_W-1:0] c_LAST_STEP = c_IDX_W'(NUM_STEPS - 1);

    seq_state_e           r_state,   w_stateNext;
    logic                 r_loadPh,  w_loadPhNext;
    logic [c_PRE_W-1:0]   r_pre,     w_preNext;
    logic [c_DUR_W-1:0]   r_durCnt,  w_durNext;
    logic [c_GAP_W-1:0]   r_gapCnt,  w_gapNext;
    logic [c_IDX_W-1:0]   r_stepIdx, w_stepNext;
    logic [c_MOD_W-1:0]   r_mod,     w_modNext;
    logic                 r_gate,    w_gateNext;

    logic [c_ENTRY_W-1:0] w_romData;
    logic [c_MOD_W-1:0]   w_romMod;
    logic [c_DUR_W-1:0]   w_romDur;
    logic                 w_tick;
    seq_state_e           w_endState, w_nxtState;
    logic [c_IDX_W-1:0]   w_endStep,  w_nxtStep;

    seq_rom #(
        .NUM_STEPS (NUM_STEPS)
    ) u_rom (
        .clockIn (clockIn),
        .i_addr  (r_stepIdx),
        .o_data  (w_romData)
    );

    assign w_romMod = w_romData[c_ENTRY_W-1:c_DUR_W];
    assign w_romDur = w_romData[c_DUR_W-1:0];
    assign w_tick   = (r_pre == c_TICK_LAST);

    // End rule and next-step rule, shared by LOAD, PLAY and GAP.
    always_comb begin
        w_endState = loop_en ? S_LOAD : S_DONE;
        w_endStep  = loop_en ? '0 : r_stepIdx;
        if (r_stepIdx == c_LAST_STEP) begin
            w_nxtState = w_endState;
            w_nxtStep  = w_endStep;
        end else begin
            w_nxtState = S_LOAD;
            w_nxtStep  = r_stepIdx + c_IDX_W'(1);
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_loadPhNext = 1'b0;
        w_preNext    = '0;
        w_durNext    = r_durCnt;
        w_gapNext    = r_gapCnt;
        w_stepNext   = r_stepIdx;
        w_modNext    = r_mod;
        w_gateNext   = r_gate;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = S_LOAD;
                    w_stepNext  = '0;
                end
            end
            S_LOAD: begin
                // First cycle waits for the registered ROM read of step_idx.
                if (!r_loadPh) begin
                    w_loadPhNext = 1'b1;
                end else if (w_romDur == '0) begin
                    w_stateNext = w_endState;
                    w_stepNext  = w_endStep;
                end else begin
                    w_modNext   = sat_add(w_romMod, offset);
                    w_durNext   = w_romDur;
                    w_gateNext  = 1'b1;
                    w_stateNext = S_PLAY;
                end
            end
            S_PLAY: begin
                w_preNext = w_tick ? '0 : r_pre + c_PRE_W'(1);
                if (w_tick) begin
                    w_durNext = r_durCnt - c_DUR_W'(1);
                    if (r_durCnt == c_DUR_W'(1)) begin
                        w_gateNext = 1'b0;
                        if (GAP_TICKS > 0) begin
                            w_stateNext = S_GAP;
                            w_gapNext   = c_GAP_LOAD;
                        end else begin
                            w_stateNext = w_nxtState;
                            w_stepNext  = w_nxtStep;
                        end
                    end
                end
            end
            S_GAP: begin
                w_preNext = w_tick ? '0 : r_pre + c_PRE_W'(1);
                if (w_tick) begin
                    w_gapNext = r_gapCnt - c_GAP_W'(1);
                    if (r_gapCnt == c_GAP_W'(1)) begin
                        w_stateNext = w_nxtState;
                        w_stepNext  = w_nxtStep;
                    end
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (stop) begin
            w_stateNext  = S_IDLE;
            w_gateNext   = 1'b0;
            w_stepNext   = r_stepIdx;
            w_modNext    = r_mod;
            w_loadPhNext = 1'b0;
            w_preNext    = '0;
        end
    end

    always_ff @(posedge clockIn) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_loadPh  <= 1'b0;
            r_pre     <= '0;
            r_durCnt  <= '0;
            r_gapCnt  <= '0;
            r_stepIdx <= '0;
            r_mod     <= '0;
            r_gate    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_loadPh  <= w_loadPhNext;
            r_pre     <= w_preNext;
            r_durCnt  <= w_durNext;
            r_gapCnt  <= w_gapNext;
            r_stepIdx <= w_stepNext;
            r_mod     <= w_modNext;
            r_gate    <= w_gateNext;
        end
    end

    assign modulador = r_mod;
    assign gate      = r_gate;
    assign step_idx  = r_stepIdx;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_melody_sequencer                                              |
// | Purpose  : Scoreboard bench: note/done events against a pattern-level model.|
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_melody_sequencer;

    localparam int TC    = 10;
    localparam int GAPT  = 1;
    localparam int NSTEP = 16;

    logic       clockIn = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       loop_en = 1'b0;
    logic [6:0] offset  = '0;
    logic [6:0] modulador;
    logic       gate;
    logic [3:0] step_idx;
    logic       busy;
    logic       done;

    always #5 clockIn = ~clockIn;

    melody_sequencer #(
        .FREC_IN   (100),
        .TICK_HZ   (10),
        .NUM_STEPS (NSTEP),
        .GAP_TICKS (GAPT)
    ) dut (
        .clockIn   (clockIn),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .offset    (offset),
        .modulador (modulador),
        .gate      (gate),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done)
    );

    // kind 0 = note (rise/fall edges), kind 1 = done pulse (rise holds its cycle)
    typedef struct {
        int kind;
        int md;
        int st;
        int rise;
        int fall;
    } ev_t;

    ev_t expQ[$];
    int  romMod[NSTEP];
    int  romDur[NSTEP];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    always @(posedge clockIn) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Walks the pattern from the rules: LOAD takes 2 cycles, notes dur*TC, gaps GAPT*TC.
    task automatic modelRun(input int e0, input int off, input bit lp, input int maxNotes);
        int  t;
        int  s;
        int  n;
        ev_t e;
        t = e0;
        s = 0;
        n = 0;
        while (n < maxNotes) begin
            if (romDur[s] == 0) begin
                if (lp) begin
                    t = t + 2;
                    s = 0;
                    continue;
                end
                e.kind = 1; e.md = 0; e.st = 0; e.rise = t + 2; e.fall = 0;
                expQ.push_back(e);
                return;
            end
            e.kind = 0;
            e.md   = (romMod[s] + off > 127) ? 127 : romMod[s] + off;
            e.st   = s;
            e.rise = t + 2;
            e.fall = e.rise + romDur[s] * TC;
            expQ.push_back(e);
            n++;
            t = e.fall + GAPT * TC;
            if (s == NSTEP - 1) begin
                if (lp) s = 0;
                else begin
                    e.kind = 1; e.md = 0; e.st = 0; e.rise = t; e.fall = 0;
                    expQ.push_back(e);
                    return;
                end
            end else begin
                s++;
            end
        end
    endtask

    // Abort/reset sampled at edge sIdx: later events vanish, a sounding note ends there.
    task automatic truncate(input int sIdx);
        ev_t keep[$];
        foreach (expQ[i]) begin
            ev_t e;
            e = expQ[i];
            if (e.rise < sIdx) begin
                if (e.kind == 0 && e.fall > sIdx) e.fall = sIdx;
                keep.push_back(e);
            end
        end
        expQ = keep;
    endtask

    ev_t mEv;
    bit  prevGate = 1'b0;
    int  riseC    = 0;
    int  riseMod  = 0;
    int  riseStep = 0;

    always @(negedge clockIn) begin
        if (gate && !prevGate) begin
            riseC    = cyc;
            riseMod  = int'(modulador);
            riseStep = int'(step_idx);
        end
        if (!gate && prevGate) begin
            if (expQ.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_note: got fall at %0d expected no note", cyc);
            end else begin
                mEv = expQ.pop_front();
                chk("note_kind", 0, mEv.kind);
                chk("note_mod", riseMod, mEv.md);
                chk("note_step", riseStep, mEv.st);
                chk("note_rise", riseC, mEv.rise);
                chk("note_fall", cyc, mEv.fall);
            end
        end
        if (done) begin
            if (expQ.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done at %0d expected none", cyc);
            end else begin
                mEv = expQ.pop_front();
                chk("done_kind", 1, mEv.kind);
                chk("done_cycle", cyc, mEv.rise);
            end
        end
        prevGate = gate;
    end

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clockIn);
    endtask

    task automatic doStart(input int off, input bit lp, input int maxNotes);
        @(negedge clockIn);
        offset  = 7'(off);
        loop_en = lp;
        start   = 1'b1;
        modelRun(cyc + 1, off, lp, maxNotes);
        @(negedge clockIn);
        start = 1'b0;
    endtask

    task automatic doStop();
        @(negedge clockIn);
        stop = 1'b1;
        truncate(cyc + 1);
        @(negedge clockIn);
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_gate", int'(gate), 0);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < budget) begin
            @(negedge clockIn);
            n++;
        end
        chk("drain_left", expQ.size(), 0);
        expQ.delete();
        waitCyc(2);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int off;
        bit lp;
        for (int i = 0; i < NSTEP; i++) begin
            romMod[i] = 0;
            romDur[i] = 0;
        end
        romMod[0] = 0;   romDur[0] = 3;
        romMod[1] = 20;  romDur[1] = 1;
        romMod[2] = 127; romDur[2] = 2;

        reset = 1'b1;
        waitCyc(3);
        chk("rst_mod",  int'(modulador), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_step", int'(step_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;

        doStart(0, 1'b0, 99);
        waitDrain(400);

        doStart(110, 1'b0, 99);
        waitDrain(400);

        doStart(0, 1'b1, 9);
        waitCyc(200);
        doStop();
        waitDrain(50);

        // abort mid first note, then replay from step 0
        doStart(0, 1'b0, 99);
        waitCyc(16);
        doStop();
        waitDrain(50);
        doStart(3, 1'b0, 99);
        waitDrain(400);

        @(negedge clockIn);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clockIn);
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        waitCyc(5);
        chk("startstop_idle", int'(busy), 0);

        // extra start during the first gap must not disturb timing
        doStart(37, 1'b0, 99);
        waitCyc(40);
        @(negedge clockIn);
        start = 1'b1;
        @(negedge clockIn);
        start = 1'b0;
        waitDrain(400);

        doStart(5, 1'b0, 99);
        waitCyc(10);
        @(negedge clockIn);
        reset = 1'b1;
        truncate(cyc + 1);
        @(negedge clockIn);
        chk("midrst_mod",  int'(modulador), 0);
        chk("midrst_gate", int'(gate), 0);
        chk("midrst_step", int'(step_idx), 0);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b0;
        waitDrain(50);

        for (int k = 0; k < 8; k++) begin
            off = int'($urandom_range(0, 127));
            lp  = 1'($urandom_range(0, 1));
            doStart(off, lp, 12);
            if (lp || $urandom_range(0, 2) == 0) begin
                waitCyc(int'($urandom_range(1, 250)));
                doStop();
            end
            waitDrain(400);
        end

        chk("queue_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
